spi_lcd_rx: RTL
===============

// Module: spi_lcd_rx
// PURPOSE
//  ILI9340-compatible SPI display sink, single clk domain: oversamples raw SPI pins, assembles bytes,
//  decodes CASET/RASET/RAMWR/RAMWRC/DISPON/DISPOFF/SWRESET, streams pixels with (x,y) to a framebuffer.
//  Successor to the spi_clk-domain display decoder: parametrised pixel size and extents, window clamping.
// PARAMETERS
//  WIDTH      16    coordinate width (bits)
//  MAX_X      1024  columns; x_end reset/clamp value MAX_X-1
//  MAX_Y      768   rows; y_end reset/clamp value MAX_Y-1
//  PIX_BYTES  2     bytes per pixel, 2 (RGB565) or 3 (RGB666); PIX_W = 8*PIX_BYTES
// PORTS
//  clk          in   1        system clock, >= 4x spi_clk
//  reset        in   1        synchronous, active-high
//  spi_clk      in   1        raw SPI clock, mode 0, MSB first
//  spi_cs       in   1        chip select, active low
//  spi_di       in   1        MOSI
//  spi_dc       in   1        1=data, 0=command
//  x, y         out  WIDTH    coordinate of current pixel
//  pixels       out  PIX_W    pixel value, first byte in MSBs
//  strobe       out  1        1-cycle pulse: x,y,pixels valid
//  x_start,x_end,y_start,y_end out WIDTH  active window
//  display_on   out  1        DISPON/DISPOFF state
// BEHAVIOUR
//  - Reset: x,y,pixels,strobe=0; x_start=y_start=0; x_end=MAX_X-1; y_end=MAX_Y-1; display_on=0;
//    cmd=0x00, param count=0, pixel byte count=0.
//  - Inputs via 2-flop synchronisers; bit sampled on detected spi_clk rise while cs low.
//    8th bit -> byte event with dc sampled at same edge; byte-to-strobe latency <= 4 clk.
//  - cs high (synced): clears bit count and pixel byte count (partial byte/pixel dropped); cmd kept.
//  - Command byte (dc=0): cmd<=byte, param count<=0. 0x28 display_on<=0; 0x29 display_on<=1;
//    0x01 restores reset values of window, x, y, display_on. 0x2C: pos<=(x_start,y_start).
//    0x3C: position continues. Unknown commands: following data bytes ignored.
//  - 0x2A params big-endian: xs_hi, xs_lo, xe_hi, xe_lo; commit x_start/x_end on 4th byte only.
//    0x2B same for y. Bytes beyond 4th ignored. Clamp: end>=MAX -> MAX-1; start>end -> end:=start;
//    start>=MAX -> start=end=MAX-1.
//  - RAMWR/RAMWRC data: bytes shifted into pixels MSB-first; on byte PIX_BYTES: strobe=1 for one
//    clk with x=pos_x,y=pos_y; then pos_x==x_end ? (pos_x<=x_start, pos_y<=pos_y==y_end ? y_start
//    : pos_y+1) : pos_x+1. Wrap is silent; no overflow outside window.
//  - Window write mid-RAMWR updates regs only; position realigns at next 0x2C.
//  - reset asserted mid-byte or mid-pixel: all state to reset values that cycle, strobe suppressed.
//  - Coordinate arithmetic mod 2^WIDTH; clamps keep values < MAX.
// CONFIGURATION
//  SPI_LCD_CMD_LOG_EN defined: adds ports uart_data out 8 and uart_strobe out 1; every command
//  byte emitted as a 1-cycle uart_strobe with uart_data=cmd (reset 0). Undefined: ports and
//  logic absent; decode behaviour identical.
// STRUCTURE
//  - Package spi_lcd_pkg: command constants (CMD_SWRESET 0x01, DISPOFF 0x28, DISPON 0x29,
//    CASET 0x2A, RASET 0x2B, RAMWR 0x2C, RAMWRC 0x3C), decoder state enum.
//  - Sub-module spi_byte_rx: synchronisers, edge detect, shift register; outputs byte, is_data,
//    byte_strobe, cs_idle. Top holds decoder FSM {IDLE, PARAM, PIXEL} and window/position regs.
// TESTING
//  - Reset then RAMWR + 2 px 0xF800,0x07E0 -> strobes at (0,0),(1,0), pixels=F800,07E0.
//  - CASET 0,10,0,12; RASET 0,5,0,6; RAMWR 6 px -> (10..12,5),(10..12,6); 7th px -> (10,5).
//  - CASET 0x0500,0x0600 with MAX_X=1024 -> x_start=x_end=1023.
//  - RAMWR 1 byte, cs high, cs low, RAMWRC 2 bytes -> one strobe, pixel = the later 2 bytes.
//  - PIX_BYTES=3: 0x2C then 12,34,56 -> pixels=0x123456, one strobe after 3rd byte.
//  - DISPON -> display_on=1; SWRESET -> display_on=0, x_end=1023; with SPI_LCD_CMD_LOG_EN
//    uart_data sequence 0x29,0x01.

Source files
------------

// File: rtl/spi_lcd_pkg.sv
// Shared constants for the SPI display sink: command opcodes and decoder states.
package spi_lcd_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PARAM,
        ST_PIXEL
    } dec_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronises the raw pins into clk,
// detects spi_clk rising edges and assembles MSB-first bytes tagged with dc.
module spi_byte_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_di,
    input  logic       spi_dc,
    output logic [7:0] data_byte,
    output logic       is_data,
    output logic       byte_strobe,
    output logic       cs_idle
);

    logic [2:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] di_sync;
    logic [1:0] dc_sync;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       sclk_rise;

    // di/dc share the spi_clk synchroniser depth, so they line up with the detected edge
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign cs_idle   = cs_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync   <= '0;
            cs_sync     <= 2'b11;
            di_sync     <= '0;
            dc_sync     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_byte   <= '0;
            is_data     <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[1:0], spi_clk};
            cs_sync     <= {cs_sync[0], spi_cs};
            di_sync     <= {di_sync[0], spi_di};
            dc_sync     <= {dc_sync[0], spi_dc};
            byte_strobe <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], di_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    data_byte   <= {shreg, di_sync[1]};
                    is_data     <= dc_sync[1];
                    byte_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_lcd_rx.sv
// ILI9340-style SPI display sink: decodes window/RAM-write commands and streams
// pixels with coordinates. Optional command log ports under SPI_LCD_CMD_LOG_EN.
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_X     = 1024,
    parameter int MAX_Y     = 768,
    parameter int PIX_BYTES = 2,
    localparam int PIX_W    = 8 * PIX_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             spi_cs,
    input  logic             spi_di,
    input  logic             spi_dc,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [PIX_W-1:0] pixels,
    output logic             strobe,
    output logic [WIDTH-1:0] x_start,
    output logic [WIDTH-1:0] x_end,
    output logic [WIDTH-1:0] y_start,
    output logic [WIDTH-1:0] y_end,
`ifdef SPI_LCD_CMD_LOG_EN
    output logic [7:0]       uart_data,
    output logic             uart_strobe,
`endif
    output logic             display_on
);

    localparam logic [WIDTH-1:0] X_LAST   = WIDTH'(MAX_X - 1);
    localparam logic [WIDTH-1:0] Y_LAST   = WIDTH'(MAX_Y - 1);
    localparam logic [1:0]       PIX_LAST = 2'(PIX_BYTES - 1);

    logic [7:0]       data_byte;
    logic             is_data;
    logic             byte_strobe;
    logic             cs_idle;
    dec_state_t       state, state_nxt;
    logic             cmd_ev, param_ev, pix_ev;
    logic [7:0]       cmd;
    logic [2:0]       param_cnt;
    logic [7:0]       prm0, prm1, prm2;
    logic [1:0]       pix_cnt;
    logic [WIDTH-1:0] pos_x, pos_y;

    spi_byte_rx u_byte_rx (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_di      (spi_di),
        .spi_dc      (spi_dc),
        .data_byte   (data_byte),
        .is_data     (is_data),
        .byte_strobe (byte_strobe),
        .cs_idle     (cs_idle)
    );

    // Returns {start, end} forced inside 0..last with start <= end
    function automatic logic [2*WIDTH-1:0] clamp_win(input logic [WIDTH-1:0] s_in,
                                                     input logic [WIDTH-1:0] e_in,
                                                     input logic [WIDTH-1:0] last);
        logic [WIDTH-1:0] s_out, e_out;
        e_out = (e_in > last) ? last : e_in;
        s_out = s_in;
        if (s_in > last) begin
            s_out = last;
            e_out = last;
        end else if (s_in > e_out) begin
            e_out = s_in;
        end
        return {s_out, e_out};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (byte_strobe && !is_data) begin
            case (data_byte)
                CMD_CASET, CMD_RASET:  state_nxt = ST_PARAM;
                CMD_RAMWR, CMD_RAMWRC: state_nxt = ST_PIXEL;
                default:               state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ev   = byte_strobe && !is_data;
        param_ev = byte_strobe && is_data && (state == ST_PARAM);
        pix_ev   = byte_strobe && is_data && (state == ST_PIXEL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            pixels     <= '0;
            strobe     <= 1'b0;
            x_start    <= '0;
            x_end      <= X_LAST;
            y_start    <= '0;
            y_end      <= Y_LAST;
            display_on <= 1'b0;
            cmd        <= 8'h00;
            param_cnt  <= '0;
            prm0       <= '0;
            prm1       <= '0;
            prm2       <= '0;
            pix_cnt    <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
        end else begin
            strobe <= 1'b0;
            if (cs_idle) pix_cnt <= '0;

            if (cmd_ev) begin
                cmd       <= data_byte;
                param_cnt <= '0;
                pix_cnt   <= '0;
                case (data_byte)
                    CMD_DISPOFF: display_on <= 1'b0;
                    CMD_DISPON:  display_on <= 1'b1;
                    CMD_SWRESET: begin
                        x_start    <= '0;
                        x_end      <= X_LAST;
                        y_start    <= '0;
                        y_end      <= Y_LAST;
                        x          <= '0;
                        y          <= '0;
                        pos_x      <= '0;
                        pos_y      <= '0;
                        display_on <= 1'b0;
                    end
                    CMD_RAMWR: begin
                        pos_x <= x_start;
                        pos_y <= y_start;
                    end
                    default: ;
                endcase
            end

            // Window registers change only once all four parameter bytes are in
            if (param_ev && param_cnt < 3'd4) begin
                param_cnt <= param_cnt + 3'd1;
                case (param_cnt)
                    3'd0: prm0 <= data_byte;
                    3'd1: prm1 <= data_byte;
                    3'd2: prm2 <= data_byte;
                    3'd3: begin
                        if (cmd == CMD_CASET)
                            {x_start, x_end} <= clamp_win(WIDTH'({prm0, prm1}),
                                                          WIDTH'({prm2, data_byte}), X_LAST);
                        else
                            {y_start, y_end} <= clamp_win(WIDTH'({prm0, prm1}),
                                                          WIDTH'({prm2, data_byte}), Y_LAST);
                    end
                    default: ;
                endcase
            end

            if (pix_ev) begin
                pixels <= {pixels[PIX_W-9:0], data_byte};
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                    strobe  <= 1'b1;
                    x       <= pos_x;
                    y       <= pos_y;
                    // >= keeps the cursor inside a window that shrank during RAMWRC
                    if (pos_x >= x_end) begin
                        pos_x <= x_start;
                        pos_y <= (pos_y >= y_end) ? y_start : pos_y + WIDTH'(1);
                    end else begin
                        pos_x <= pos_x + WIDTH'(1);
                    end
                end else begin
                    pix_cnt <= pix_cnt + 2'd1;
                end
            end
        end
    end

`ifdef SPI_LCD_CMD_LOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_data   <= 8'h00;
            uart_strobe <= 1'b0;
        end else begin
            uart_strobe <= cmd_ev;
            if (cmd_ev) uart_data <= data_byte;
        end
    end
`endif

endmodule
